// File: rtl/round_key_add.sv
// round_key_add: AES-128 AddRoundKey stage with an on-the-fly key schedule.
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a block (sampled only in IDLE)
//   message    plaintext, byte 0 in bits [127:120], column-major
//   key        cipher key, same byte order, sampled with start
//   fb_valid   fb_state valid for the next round (sampled only in WAIT)
//   fb_state   state returned from MixColumns (rounds 1-9) or ShiftRows (round 10)
//   crypte     registered state ^ round key, feeds SubBytes
//   out_valid  one-cycle pulse: crypte holds a new round result
//   round      round index of the current crypte, 0..10
//   last       pulses with out_valid on round 10
//   busy       high while waiting for feedback
module round_key_add (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] message,
   input  logic [127:0] key,
   input  logic         fb_valid,
   input  logic [127:0] fb_state,
   output logic [127:0] crypte,
   output logic         out_valid,
   output logic [3:0]   round,
   output logic         last,
   output logic         busy
);
   typedef enum logic {IDLE, WAIT} state_t;
   // Entry b of a byte table packed MSB-first sits at [{~b,3'b111} -: 8].
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   // rcon[round+1] indexed by the round currently held in the register.
   localparam logic [127:0] RCON = 128'h01020408102040801b36000000000000;
   state_t state;
   logic [127:0] rk_reg, rk_next;
   logic [31:0]  rot, t, w0, w1, w2, w3;
   logic [7:0]   rc;
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction
   always_comb begin
      rc  = RCON[{~round, 3'b111} -: 8];
      rot = {rk_reg[23:0], rk_reg[31:24]};
      t   = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      w0  = rk_reg[127:96] ^ t;
      w1  = rk_reg[95:64] ^ w0;
      w2  = rk_reg[63:32] ^ w1;
      w3  = rk_reg[31:0] ^ w2;
      rk_next = {w0, w1, w2, w3};
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         crypte    <= '0;
         rk_reg    <= '0;
         round     <= '0;
         out_valid <= 1'b0;
         last      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         last      <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               crypte    <= message ^ key;
               rk_reg    <= key;
               round     <= 4'd0;
               out_valid <= 1'b1;
               busy      <= 1'b1;
               state     <= WAIT;
            end
         end else if (fb_valid) begin
            crypte    <= fb_state ^ rk_next;
            rk_reg    <= rk_next;
            round     <= round + 4'd1;
            out_valid <= 1'b1;
            if (round == 4'd9) begin
               last  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_round_key_add.sv
// tb_round_key_add: randomized self-checking bench against a behavioural AES-128 model.
module tb_round_key_add;
   logic         clk = 0, rst_n = 0, start = 0, fb_valid = 0;
   logic [127:0] message = 0, key = 0, fb_state = 0;
   logic [127:0] crypte;
   logic [3:0]   round;
   logic         out_valid, last, busy;
   int           total = 0, bad = 0;
   logic [7:0]   sb [0:255];
   logic [127:0] rk [0:10];
   logic [127:0] hist [0:10];
   localparam logic [127:0] FIPS_M = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   always #5 clk = ~clk;

   round_key_add dut (
      .clk(clk), .rst_n(rst_n), .start(start), .message(message), .key(key),
      .fb_valid(fb_valid), .fb_state(fb_state), .crypte(crypte),
      .out_valid(out_valid), .round(round), .last(last), .busy(busy)
   );

   task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [135:0] obs();
      return {1'b0, crypte, out_valid, last, busy, round};
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
      return v;
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand_key(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[32*(3-i) +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // SubBytes, ShiftRows and optionally MixColumns on a column-major state.
   function automatic logic [127:0] enc_round(input logic [127:0] s, input bit mix);
      logic [7:0]   a [0:15];
      logic [7:0]   b [0:15];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) a[i] = sb[s[8*(15-i) +: 8]];
      for (int i = 0; i < 16; i++) b[i] = a[i%4 + 4*((i/4 + i%4) % 4)];
      o = 0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(15-(4*c+r)) +: 8] = mix ?
               gmul(8'h02, b[4*c+r]) ^ gmul(8'h03, b[4*c+(r+1)%4]) ^ b[4*c+(r+2)%4] ^ b[4*c+(r+3)%4] :
               b[4*c+r];
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: zero feedback, 1: real AES round feedback, 2: random feedback.
   task automatic run_block(input logic [127:0] m, input logic [127:0] k, input int mode,
                            input int max_gap, input bit both);
      logic [127:0] prev, fbs, e;
      int ov, g;
      expand_key(k);
      message = m; key = k; start = 1; fb_valid = both; fb_state = rnd128();
      tick();
      start = 0; fb_valid = 0;
      ov = out_valid;
      prev = m ^ k;
      chk("round0", obs(), {1'b0, prev, 1'b1, 1'b0, 1'b1, 4'd0});
      hist[0] = crypte;
      for (int r = 1; r <= 10; r++) begin
         g = $urandom_range(max_gap, 0);
         repeat (g) begin
            start = 1'($urandom_range(1, 0)); message = rnd128(); key = rnd128();
            tick();
            ov += out_valid;
            chk($sformatf("gap_r%0d", r), obs(), {1'b0, prev, 1'b0, 1'b0, 1'b1, 4'(r-1)});
         end
         start = 0;
         fbs = mode == 0 ? 128'h0 : mode == 1 ? enc_round(prev, r < 10) : rnd128();
         fb_valid = 1; fb_state = fbs;
         tick();
         fb_valid = 0;
         ov += out_valid;
         e = fbs ^ rk[r];
         chk($sformatf("r%0d", r), obs(), {1'b0, e, 1'b1, 1'(r == 10), 1'(r != 10), 4'(r)});
         prev = e;
         hist[r] = crypte;
      end
      chk("ov_count", 136'(ov), 136'(11));
   endtask

   initial begin
      logic [127:0] held;
      build_sbox();
      repeat (3) tick();
      chk("reset", obs(), 136'h0);
      rst_n = 1;
      tick();
      chk("post_reset_idle", obs(), 136'h0);

      run_block(FIPS_M, FIPS_K, 0, 0, 0);
      chk("fips_r0", 136'(hist[0]), 136'(128'h193de3bea0f4e22b9ac68d2ae9f84808));
      chk("fips_rk1", 136'(hist[1]), 136'(128'ha0fafe1788542cb123a339392a6c7605));
      chk("fips_rk10", 136'(hist[10]), 136'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

      held = crypte;
      fb_valid = 1; fb_state = rnd128();
      repeat (2) begin
         tick();
         chk("fb_in_idle", obs(), {1'b0, held, 1'b0, 1'b0, 1'b0, 4'd10});
      end
      fb_valid = 0;

      run_block(FIPS_M, FIPS_K, 1, 0, 0);
      chk("fips_ct", 136'(hist[10]), 136'(128'h3925841d02dc09fbdc118597196a0b32));
      run_block(FIPS_M, FIPS_K, 1, 5, 1);
      chk("fips_ct_gapped", 136'(hist[10]), 136'(128'h3925841d02dc09fbdc118597196a0b32));

      message = rnd128(); key = rnd128(); start = 1;
      tick();
      start = 0;
      repeat (6) begin
         fb_valid = 1; fb_state = rnd128();
         tick();
      end
      fb_valid = 0;
      chk("pre_reset_round", 136'(round), 136'(6));
      rst_n = 0;
      tick();
      chk("mid_reset", obs(), 136'h0);
      rst_n = 1;
      fb_valid = 1;
      tick();
      fb_valid = 0;
      chk("after_reset_idle", obs(), 136'h0);
      run_block(rnd128(), rnd128(), 2, 2, 0);

      for (int i = 0; i < 8; i++)
         run_block(rnd128(), rnd128(), 1 + (i % 2), $urandom_range(5, 0), 1'($urandom_range(1, 0)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
